// File: rtl/bingo_mark_engine.sv
// bingo_mark_engine: marks called numbers on a 5x5 board, counts completed lines and feeds Display_top
module bingo_mark_engine #(
   parameter int WIN_LINES = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [124:0] map_in,
   input  logic         mark_valid,
   input  logic [4:0]   mark_num,
   output logic         mark_ready,
   output logic [124:0] map,
   output logic [24:0]  circle,
   output logic [7:0]   display_nums,
   output logic [3:0]   lines,
   output logic         found,
   output logic         bingo,
   output logic         done
);
   localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, COUNT = 2'd2, DONE = 2'd3;
   logic [1:0]  state;
   logic [4:0]  num, idx;
   logic [3:0]  li, acc, acc_n;
   logic        hit, match;
   logic [6:0]  base;
   logic [24:0] mask;
   function automatic logic [24:0] line_mask(input int l);
      logic [24:0] m;
      int r, c;
      m = '0;
      for (int k = 0; k < 25; k++) begin
         r = k / 5;
         c = k % 5;
         m[24-k] = (l < 5 && r == l) || (l >= 5 && l < 10 && c == l - 5) ||
                   (l == 10 && r == c) || (l == 11 && r + c == 4);
      end
      return m;
   endfunction
   always_comb begin
      base  = 7'd124 - 7'd5 * {2'b00, idx};
      match = map[base -: 5] == num && num != 5'd0 && num <= 5'd25;
      mask  = line_mask(int'(li));
      acc_n = acc + {3'b000, (circle & mask) == mask};
   end
   assign mark_ready = state == IDLE;
   assign done       = state == DONE;
   // results are committed on the last COUNT edge so they are visible while done is high
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         map          <= '0;
         circle       <= '0;
         lines        <= '0;
         display_nums <= '0;
         found        <= 1'b0;
         bingo        <= 1'b0;
         num          <= '0;
         idx          <= '0;
         li           <= '0;
         acc          <= '0;
         hit          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  map          <= map_in;
                  circle       <= '0;
                  lines        <= '0;
                  found        <= 1'b0;
                  display_nums <= '0;
                  bingo        <= 1'b0;
               end else if (mark_valid) begin
                  num   <= mark_num;
                  idx   <= '0;
                  hit   <= 1'b0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (match) begin
                  hit               <= 1'b1;
                  circle[5'd24-idx] <= 1'b1;
               end
               idx <= idx + 5'd1;
               if (idx == 5'd24) begin
                  li    <= '0;
                  acc   <= '0;
                  state <= COUNT;
               end
            end
            COUNT: begin
               acc <= acc_n;
               li  <= li + 4'd1;
               if (li == 4'd11) begin
                  lines        <= acc_n;
                  found        <= hit;
                  display_nums <= acc_n >= 4'd10 ? {4'd1, acc_n - 4'd10} : {4'd0, acc_n};
                  bingo        <= 32'(acc_n) >= WIN_LINES;
                  state        <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bingo_mark_engine.sv
// tb_bingo_mark_engine: directed marks with a scoreboard checked on every done pulse
module tb_bingo_mark_engine;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0;
   logic [124:0] map_in = '0;
   logic         mark_valid = 1'b0;
   logic [4:0]   mark_num = '0;
   logic         mark_ready;
   logic [124:0] map;
   logic [24:0]  circle;
   logic [7:0]   display_nums;
   logic [3:0]   lines;
   logic         found, bingo, done;
   int errors = 0;
   int checks = 0;
   typedef struct {
      logic        full;
      logic        found;
      logic [24:0] circle;
      logic [3:0]  lines;
      logic [7:0]  disp;
      logic        bingo;
   } exp_t;
   exp_t q[$];
   logic [4:0]   bv [25] = '{1,12,19,20,21,22,23,24,25,2,3,4,5,6,7,8,9,10,11,13,14,15,16,17,18};
   logic [4:0]   rem [16] = '{2,3,4,6,7,8,9,10,13,14,15,16,17,22,24,25};
   logic [124:0] board;
   bingo_mark_engine #(.WIN_LINES(5)) dut (
      .clk(clk), .rst(rst), .load(load), .map_in(map_in), .mark_valid(mark_valid),
      .mark_num(mark_num), .mark_ready(mark_ready), .map(map), .circle(circle),
      .display_nums(display_nums), .lines(lines), .found(found), .bingo(bingo), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) chk("unexpected_done", 128'(done), 128'(0));
         else begin
            exp_t e;
            e = q.pop_front();
            chk("found", 128'(found), 128'(e.found));
            if (e.full) begin
               chk("circle", 128'(circle), 128'(e.circle));
               chk("lines", 128'(lines), 128'(e.lines));
               chk("display_nums", 128'(display_nums), 128'(e.disp));
               chk("bingo", 128'(bingo), 128'(e.bingo));
            end
         end
      end
   end
   task automatic mark(input logic [4:0] n, input logic full, input logic f, input logic [24:0] c,
                       input logic [3:0] l, input logic [7:0] d, input logic bg);
      int cyc;
      logic rdy_bad;
      q.push_back('{full, f, c, l, d, bg});
      @(negedge clk);
      mark_valid = 1'b1;
      mark_num   = n;
      @(posedge clk);
      #1;
      mark_valid = 1'b0;
      cyc = 1;
      rdy_bad = 1'b0;
      while (!done && cyc < 60) begin
         if (mark_ready) rdy_bad = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("done_latency", 128'(cyc), 128'(38));
      chk("ready_low_busy", 128'(rdy_bad), 128'(0));
      chk("ready_low_done", 128'(mark_ready), 128'(0));
      @(posedge clk);
      #1;
      chk("done_one_cycle", 128'(done), 128'(0));
      chk("ready_back", 128'(mark_ready), 128'(1));
   endtask
   task automatic do_load();
      @(negedge clk);
      load   = 1'b1;
      map_in = board;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask
   task automatic chk_reset();
      chk("rst_map", 128'(map), 128'(0));
      chk("rst_circle", 128'(circle), 128'(0));
      chk("rst_lines", 128'(lines), 128'(0));
      chk("rst_disp", 128'(display_nums), 128'(0));
      chk("rst_found", 128'(found), 128'(0));
      chk("rst_bingo", 128'(bingo), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_ready", 128'(mark_ready), 128'(1));
   endtask
   initial begin
      for (int k = 0; k < 25; k++) board[124-5*k -: 5] = bv[k];
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset();
      do_load();
      chk("load_map", 128'(map), 128'(board));
      mark(12, 1, 1, 25'h0800000, 0, 8'h00, 0);
      mark(1,  1, 1, 25'h1800000, 0, 8'h00, 0);
      mark(19, 1, 1, 25'h1C00000, 0, 8'h00, 0);
      mark(20, 1, 1, 25'h1E00000, 0, 8'h00, 0);
      mark(21, 1, 1, 25'h1F00000, 1, 8'h01, 0);
      mark(0,  1, 0, 25'h1F00000, 1, 8'h01, 0);
      mark(26, 1, 0, 25'h1F00000, 1, 8'h01, 0);
      mark(23, 1, 1, 25'h1F40000, 1, 8'h01, 0);
      mark(5,  1, 1, 25'h1F41000, 1, 8'h01, 0);
      mark(11, 1, 1, 25'h1F41040, 1, 8'h01, 0);
      mark(18, 1, 1, 25'h1F41041, 2, 8'h02, 0);
      mark(23, 1, 1, 25'h1F41041, 2, 8'h02, 0);
      for (int i = 0; i < 15; i++) mark(rem[i], 0, 1, '0, 0, 8'h00, 0);
      mark(rem[15], 1, 1, 25'h1FFFFFF, 12, 8'h12, 1);
      do_load();
      chk("reload_circle", 128'(circle), 128'(0));
      chk("reload_lines", 128'(lines), 128'(0));
      chk("reload_bingo", 128'(bingo), 128'(0));
      chk("reload_disp", 128'(display_nums), 128'(0));
      @(negedge clk);
      mark_valid = 1'b1;
      mark_num   = 5'd12;
      @(posedge clk);
      #1;
      mark_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset();
      repeat (45) @(posedge clk);
      #1;
      chk("rst_no_scan_ready", 128'(mark_ready), 128'(1));
      @(negedge clk);
      load       = 1'b1;
      map_in     = board;
      mark_valid = 1'b1;
      mark_num   = 5'd12;
      @(posedge clk);
      #1;
      load       = 1'b0;
      mark_valid = 1'b0;
      chk("both_map", 128'(map), 128'(board));
      chk("both_ready", 128'(mark_ready), 128'(1));
      repeat (45) @(posedge clk);
      #1;
      chk("both_circle", 128'(circle), 128'(0));
      chk("both_ready_late", 128'(mark_ready), 128'(1));
      chk("queue_empty", 128'(q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
